arb_requester: RTL and testbench

ARB_REQUESTER -- requirements
Module: arb_requester

---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_req_fifo.sv | 70 +++++++
 rtl/arb_requester.sv | 119 +++++++++++
 tb/tb_arb_requester.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter requester: channel count, index type and grant helpers.
package arb_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef logic [CH_W-1:0] ch_idx_t;

  // True when more than one bit of v is set.
  function automatic logic is_multi_hot(input logic [NUM_CH-1:0] v);
    return |(v & (v - {{(NUM_CH-1){1'b0}}, 1'b1}));
  endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Single-channel request queue: DEPTH entries of DATA_W bits, head exposed combinationally.
module arb_req_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full_o    = (count_q == CNT_DEPTH);
  assign empty_o   = (count_q == CNT_ZERO);
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  // Fullness is judged on the pre-edge count, so a push into a full queue is lost even if it pops.
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;

  // Next-state pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_ok_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while count says empty.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/arb_requester.sv
// Four queued requesters feeding a round-robin arbiter; serviced payload returned one cycle after grant.
// Optional grant protocol checker enabled by defining ARB_REQUESTER_GRANT_CHECK_EN.
module arb_requester
  import arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic [NUM_CH-1:0]        i_wr_en,
  input  logic [NUM_CH*DATA_W-1:0] i_wr_data,
  output logic [NUM_CH-1:0]        o_full,
  output logic [NUM_CH-1:0]        o_req,
  input  logic [NUM_CH-1:0]        i_grant,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_data,
  output logic [CH_W-1:0]          o_ch,
  output logic                     o_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] head_s  [NUM_CH];
  logic [CNT_W-1:0]  count_s [NUM_CH];
  logic [NUM_CH-1:0] empty_s;
  logic [NUM_CH-1:0] pop_s;
  logic              pop_any_s;
  ch_idx_t           sel_ch_s;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  ch_idx_t           ch_q, ch_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    arb_req_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .push_i  (i_wr_en[g]),
      .pop_i   (pop_s[g]),
      .data_i  (i_wr_data[g*DATA_W +: DATA_W]),
      .data_o  (head_s[g]),
      .count_o (count_s[g]),
      .full_o  (o_full[g]),
      .empty_o (empty_s[g])
    );
    assign o_req[g] = (count_s[g] != CNT_W'(0));
  end

  // Service only the lowest-index channel that is both granted and non-empty.
  always_comb begin
    pop_s     = '0;
    pop_any_s = 1'b0;
    sel_ch_s  = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (i_grant[n] && !empty_s[n] && !pop_any_s) begin
        pop_s[n]  = 1'b1;
        pop_any_s = 1'b1;
        sel_ch_s  = ch_idx_t'(n);
      end else begin
      end
    end
  end

  // Transfer outputs hold their payload between strobes.
  always_comb begin
    valid_d = pop_any_s;
    if (pop_any_s) begin
      data_d = head_s[sel_ch_s];
      ch_d   = sel_ch_s;
    end else begin
      data_d = data_q;
      ch_d   = ch_q;
    end
  end

  // Registered transfer outputs.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_ch    = ch_q;

`ifdef ARB_REQUESTER_GRANT_CHECK_EN
  logic err_q, err_d;

  // A grant is illegal when multi-hot or aimed at a channel not currently requesting.
  always_comb begin
    err_d = err_q | is_multi_hot(i_grant) | (|(i_grant & ~o_req));
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Scoreboard bench for arb_requester: directed scenarios followed by randomized traffic against a queue model.
module tb_arb_requester;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int NC = 4;

  logic            clk;
  logic            i_rst_n;
  logic [NC-1:0]   i_wr_en;
  logic [NC*DW-1:0] i_wr_data;
  logic [NC-1:0]   o_full;
  logic [NC-1:0]   o_req;
  logic [NC-1:0]   i_grant;
  logic            o_valid;
  logic [DW-1:0]   o_data;
  logic [1:0]      o_ch;
  logic            o_err;

  arb_requester #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk       (clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (i_wr_en),
    .i_wr_data (i_wr_data),
    .o_full    (o_full),
    .o_req     (o_req),
    .i_grant   (i_grant),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_ch      (o_ch),
    .o_err     (o_err)
  );

  typedef struct {
    logic [1:0]    ch;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mq[NC][$];
  logic          err_m;
  int            checks = 0;
  int            errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every DUT transfer must match the oldest expected transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (i_rst_n === 1'b1 && o_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("sb_spurious_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_data", {24'd0, o_data}, {24'd0, e.data});
          chk("sb_ch", {30'd0, o_ch}, {30'd0, e.ch});
        end
      end
    end
  end

  // One clock of stimulus: model the edge from the spec rules, then compare flags after it.
  task automatic step(input logic [NC-1:0] we, input logic [NC*DW-1:0] wd, input logic [NC-1:0] gr);
    int pc;
    logic [NC-1:0] acc;
    exp_t e;
    i_wr_en   = we;
    i_wr_data = wd;
    i_grant   = gr;
    pc = -1;
    for (int n = 0; n < NC; n++) begin
      if (gr[n] && mq[n].size() != 0 && pc < 0) pc = n;
      acc[n] = we[n] && (mq[n].size() < DP);
    end
`ifdef ARB_REQUESTER_GRANT_CHECK_EN
    if ($countones(gr) > 1) err_m = 1'b1;
    for (int n = 0; n < NC; n++) begin
      if (gr[n] && mq[n].size() == 0) err_m = 1'b1;
    end
`endif
    if (pc >= 0) begin
      e.ch   = pc[1:0];
      e.data = mq[pc].pop_front();
      sb.push_back(e);
    end
    for (int n = 0; n < NC; n++) begin
      if (acc[n]) mq[n].push_back(wd[n*DW +: DW]);
    end
    @(posedge clk);
    @(negedge clk);
    chk("valid", {31'd0, o_valid}, {31'd0, (pc >= 0)});
    for (int n = 0; n < NC; n++) begin
      chk($sformatf("req%0d", n), {31'd0, o_req[n]}, {31'd0, (mq[n].size() != 0)});
      chk($sformatf("full%0d", n), {31'd0, o_full[n]}, {31'd0, (mq[n].size() == DP)});
    end
    chk("err", {31'd0, o_err}, {31'd0, err_m});
  endtask

  function automatic logic [NC*DW-1:0] on_ch(input int ch, input logic [DW-1:0] d);
    logic [NC*DW-1:0] v;
    v = '0;
    v[ch*DW +: DW] = d;
    return v;
  endfunction

  // Asynchronous reset mid-cycle, checked before any clock edge can act.
  task automatic do_reset();
    i_rst_n   = 1'b0;
    i_wr_en   = '0;
    i_wr_data = '0;
    i_grant   = '0;
    #1;
    chk("rst_req", {28'd0, o_req}, 32'd0);
    chk("rst_full", {28'd0, o_full}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_data", {24'd0, o_data}, 32'd0);
    chk("rst_ch", {30'd0, o_ch}, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    for (int n = 0; n < NC; n++) mq[n].delete();
    sb.delete();
    err_m = 1'b0;
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    logic [NC-1:0] gr;
    int r;
    i_rst_n   = 1'b0;
    i_wr_en   = '0;
    i_wr_data = '0;
    i_grant   = '0;
    err_m     = 1'b0;
    @(negedge clk);
    do_reset();

    // Single push and grant on ch2.
    step(4'b0100, on_ch(2, 8'hA5), 4'b0000);
    chk("s1_req", {28'd0, o_req}, 32'h4);
    step(4'b0000, '0, 4'b0100);
    chk("s1_valid", {31'd0, o_valid}, 32'd1);
    chk("s1_data", {24'd0, o_data}, 32'hA5);
    chk("s1_ch", {30'd0, o_ch}, 32'd2);
    chk("s1_req_clr", {28'd0, o_req}, 32'd0);

    // Fill ch0, overflow push dropped, drain in order.
    for (int i = 1; i <= 4; i++) step(4'b0001, on_ch(0, 8'(i)), 4'b0000);
    chk("s2_full", {31'd0, o_full[0]}, 32'd1);
    step(4'b0001, on_ch(0, 8'd5), 4'b0000);
    for (int i = 0; i < 4; i++) step(4'b0000, '0, 4'b0001);
    chk("s2_empty", {31'd0, o_req[0]}, 32'd0);

    // Rotating grants over ch1 and ch3.
    step(4'b1010, on_ch(1, 8'h11) | on_ch(3, 8'h33), 4'b0000);
    step(4'b0000, '0, 4'b0001);
    step(4'b0000, '0, 4'b0010);
    chk("s3_ch1", {30'd0, o_ch}, 32'd1);
    step(4'b0000, '0, 4'b0100);
    step(4'b0000, '0, 4'b1000);
    chk("s3_ch3", {30'd0, o_ch}, 32'd3);

    // Full ch0 with simultaneous push and pop: head popped, push dropped.
    for (int i = 0; i < 4; i++) step(4'b0001, on_ch(0, 8'(8'h10 + i)), 4'b0000);
    step(4'b0001, on_ch(0, 8'd9), 4'b0001);
    chk("s4_data", {24'd0, o_data}, 32'h10);
    chk("s4_not_full", {31'd0, o_full[0]}, 32'd0);
    for (int i = 0; i < 3; i++) step(4'b0000, '0, 4'b0001);
    chk("s4_drained", {31'd0, o_req[0]}, 32'd0);

    // Multi-hot grant serves the lowest channel only.
    do_reset();
    step(4'b0011, on_ch(0, 8'h21) | on_ch(1, 8'h22), 4'b0000);
    step(4'b0000, '0, 4'b0011);
    chk("s5_ch", {30'd0, o_ch}, 32'd0);
    chk("s5_ch1_left", {31'd0, o_req[1]}, 32'd1);
    step(4'b0000, '0, 4'b0010);
    step(4'b0000, '0, 4'b0000);

    // Reset with queued entries, then clean restart.
    for (int i = 0; i < 3; i++) step(4'b0100, on_ch(2, 8'(8'h40 + i)), 4'b0000);
    do_reset();
    step(4'b0100, on_ch(2, 8'h77), 4'b0000);
    step(4'b0000, '0, 4'b0100);
    chk("s6_data", {24'd0, o_data}, 32'h77);

    // Randomized traffic, mostly one-hot grants.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) gr = 4'b0000;
      else if (r < 9) gr = 4'(1 << $urandom_range(0, 3));
      else gr = 4'($urandom_range(0, 15));
      step(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
           {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, gr);
    end

    // Drain everything that remains.
    for (int i = 0; i < 4 * DP; i++) step(4'b0000, '0, 4'(1 << (i % NC)));
    step(4'b0000, '0, 4'b0000);
    chk("sb_leftover", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the directed and random phases are far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
